// File: rtl/rv_pkg.sv
// Shared RV32 encodings for the multi-cycle core: control-word field values,
// opcode constants and the reset instruction.
package rv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'b00,
    SRC_A_OLD_PC = 2'b01,
    SRC_A_REG    = 2'b10,
    SRC_A_ZERO   = 2'b11
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_REG  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10,
    SRC_B_ZERO = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    RES_ALU_OUT    = 2'b00,
    RES_DATA       = 2'b01,
    RES_ALU_RESULT = 2'b10,
    RES_IMM        = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/reg_file.sv
// 32x32 register file, two combinational read ports and one write port.
// x0 always reads zero and ignores writes; reset clears every entry.
module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  // No bypass: a write becomes visible only after its edge.
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32 datapath: PC, register file, IR/OldPC/Data/A/B/ALUOut
// latches, immediate extender, ALU and result mux, driven by the control FSM.
module multicycle_datapath
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        ir_write,
  input  logic        reg_write,
  input  logic        mem_write,
  input  logic        adr_src,
  input  logic [1:0]  alu_src_a,
  input  logic [1:0]  alu_src_b,
  input  logic [1:0]  result_src,
  input  logic [2:0]  alu_control,
  input  logic [2:0]  imm_src,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        zero,
  output logic [31:0] pc_out
);

  logic [31:0] pc, old_pc, ir, data, a, b, alu_out;
  logic [31:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, result;

  reg_file u_reg_file (
    .clk   (clk),
    .reset (reset),
    .we    (reg_write),
    .ra1   (ir[19:15]),
    .ra2   (ir[24:20]),
    .wa    (ir[11:7]),
    .wd    (result),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  // Reset takes priority over every enable, abandoning any partial instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      old_pc  <= '0;
      ir      <= NOP_INSTR;
      data    <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      a       <= rd1;
      b       <= rd2;
      alu_out <= alu_result;
      data    <= mem_rdata;
      if (pc_write) pc <= result;
      if (ir_write) begin
        ir     <= mem_rdata;
        old_pc <= pc;
      end
    end
  end

  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I:   imm_ext = {{20{ir[31]}}, ir[31:20]};
      IMM_S:   imm_ext = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm_ext = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_J:   imm_ext = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      IMM_U:   imm_ext = {ir[31:12], 12'b0};
      default: imm_ext = '0;
    endcase
  end

  always_comb begin
    src_a = '0;
    case (alu_src_a)
      SRC_A_PC:     src_a = pc;
      SRC_A_OLD_PC: src_a = old_pc;
      SRC_A_REG:    src_a = a;
      default:      src_a = '0;
    endcase
  end

  always_comb begin
    src_b = '0;
    case (alu_src_b)
      SRC_B_REG:  src_b = b;
      SRC_B_IMM:  src_b = imm_ext;
      SRC_B_FOUR: src_b = 32'd4;
      default:    src_b = '0;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLT: alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
      ALU_SLL: alu_result = src_a << src_b[4:0];
      ALU_SRL: alu_result = src_a >> src_b[4:0];
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    result = '0;
    case (result_src)
      RES_ALU_OUT:    result = alu_out;
      RES_DATA:       result = data;
      RES_ALU_RESULT: result = alu_result;
      default:        result = imm_ext;
    endcase
  end

  assign zero      = (alu_result == 32'd0);
  assign mem_addr  = adr_src ? result : pc;
  assign mem_wdata = b;
  assign mem_we    = mem_write;
  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign funct7    = ir[31:25];
  assign pc_out    = pc;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: immediate and ALU vector tables plus
// hand-sequenced instruction flows, reset and write-ordering corner cases.
module tb_multicycle_datapath;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, pc_write, ir_write, reg_write, mem_write, adr_src;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_control, imm_src;
  logic [31:0] mem_rdata, mem_addr, mem_wdata, pc_out;
  logic        mem_we, zero;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] exp;
  } imm_vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctl;
    logic [31:0] exp;
    logic        exp_zero;
  } alu_vec_t;

  imm_vec_t imm_tab[10];
  alu_vec_t alu_tab[12];

  multicycle_datapath #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .alu_control (alu_control),
    .imm_src     (imm_src),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .zero        (zero),
    .pc_out      (pc_out)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    reset = 1'b0; pc_write = 1'b0; ir_write = 1'b0; reg_write = 1'b0;
    mem_write = 1'b0; adr_src = 1'b0; alu_src_a = 2'b00; alu_src_b = 2'b00;
    result_src = 2'b00; alu_control = 3'b000; imm_src = 3'b000; mem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] rd, input logic [31:0] val,
                           input logic [4:0] rs1, input logic [4:0] rs2);
    idle(); ir_write = 1'b1; mem_rdata = {7'b0, rs2, rs1, 3'b000, rd, 7'h33}; tick();
    idle(); mem_rdata = val; tick();
    idle(); reg_write = 1'b1; result_src = 2'b01; tick();
    idle();
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [31:0] val);
    idle(); ir_write = 1'b1; mem_rdata = {12'b0, r, 3'b000, 5'b0, 7'h13}; tick();
    idle(); tick();
    adr_src = 1'b1; alu_src_a = 2'b10; alu_src_b = 2'b11; result_src = 2'b10; #1;
    val = mem_addr;
    idle();
  endtask

  task automatic load_pc(input logic [31:0] val);
    write_reg(5'd3, val, 5'd3, 5'd0);
    tick();
    pc_write = 1'b1; alu_src_a = 2'b10; alu_src_b = 2'b11; result_src = 2'b10; tick();
    idle();
  endtask

  task automatic fetch(input logic [31:0] instr);
    idle(); pc_write = 1'b1; ir_write = 1'b1; alu_src_b = 2'b10;
    result_src = 2'b10; mem_rdata = instr; tick();
    idle();
  endtask

  logic [31:0] rv;

  initial begin
    imm_tab[0] = '{32'hFFF0_0093, 3'b000, 32'hFFFF_FFFF};
    imm_tab[1] = '{32'h7FF0_0093, 3'b000, 32'h0000_07FF};
    imm_tab[2] = '{32'hFE11_2E23, 3'b001, 32'hFFFF_FFFC};
    imm_tab[3] = '{32'hFE00_0CE3, 3'b010, 32'hFFFF_FFF8};
    imm_tab[4] = '{32'h0000_00E3, 3'b010, 32'h0000_0800};
    imm_tab[5] = '{32'h0100_00EF, 3'b011, 32'h0000_0010};
    imm_tab[6] = '{32'h000F_F06F, 3'b011, 32'h000F_F000};
    imm_tab[7] = '{32'h8000_006F, 3'b011, 32'hFFF0_0000};
    imm_tab[8] = '{32'h1234_5037, 3'b100, 32'h1234_5000};
    imm_tab[9] = '{32'hFFFF_FFFF, 3'b101, 32'h0000_0000};

    alu_tab[0]  = '{32'hFFFF_FFFF, 32'h1,         3'b000, 32'h0,         1'b1};
    alu_tab[1]  = '{32'h5,         32'h7,         3'b000, 32'hC,         1'b0};
    alu_tab[2]  = '{32'h5,         32'h7,         3'b001, 32'hFFFF_FFFE, 1'b0};
    alu_tab[3]  = '{32'h9,         32'h9,         3'b001, 32'h0,         1'b1};
    alu_tab[4]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010, 32'hF000_F000, 1'b0};
    alu_tab[5]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011, 32'hFFF0_FFF0, 1'b0};
    alu_tab[6]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 32'h0FF0_0FF0, 1'b0};
    alu_tab[7]  = '{32'hFFFF_FFFF, 32'h1,         3'b101, 32'h1,         1'b0};
    alu_tab[8]  = '{32'h1,         32'hFFFF_FFFF, 3'b101, 32'h0,         1'b1};
    alu_tab[9]  = '{32'h1,         32'd33,        3'b110, 32'h2,         1'b0};
    alu_tab[10] = '{32'h8000_0000, 32'd31,        3'b111, 32'h1,         1'b0};
    alu_tab[11] = '{32'h8000_0000, 32'd4,         3'b111, 32'h0800_0000, 1'b0};

    // reset state
    idle(); reset = 1'b1; tick(); tick();
    check("rst_pc", pc_out, RESET_PC);
    check("rst_opcode", {25'b0, opcode}, 32'h13);
    check("rst_funct3", {29'b0, funct3}, 32'h0);
    check("rst_funct7", {25'b0, funct7}, 32'h0);
    check("rst_mem_addr", mem_addr, RESET_PC);
    check("rst_wdata", mem_wdata, 32'h0);
    alu_src_a = 2'b11; alu_src_b = 2'b11; mem_write = 1'b1; #1;
    check("rst_zero", {31'b0, zero}, 32'h1);
    check("rst_mem_we", {31'b0, mem_we}, 32'h1);
    idle();
    read_reg(5'd1, rv);  check("rst_x1", rv, 32'h0);
    read_reg(5'd31, rv); check("rst_x31", rv, 32'h0);

    // immediate extender table
    for (int i = 0; i < 10; i++) begin
      idle(); ir_write = 1'b1; mem_rdata = imm_tab[i].instr; tick();
      idle(); adr_src = 1'b1; result_src = 2'b11; imm_src = imm_tab[i].sel; #1;
      check($sformatf("imm_%0d", i), mem_addr, imm_tab[i].exp);
    end

    // ALU table: x5 = a, x6 = b, IR selects rs1=x5 rs2=x6
    for (int i = 0; i < 12; i++) begin
      write_reg(5'd5, alu_tab[i].a, 5'd0, 5'd0);
      write_reg(5'd6, alu_tab[i].b, 5'd5, 5'd6);
      tick();
      adr_src = 1'b1; alu_src_a = 2'b10; alu_src_b = 2'b00;
      alu_control = alu_tab[i].ctl; result_src = 2'b10; #1;
      check($sformatf("alu_%0d", i), mem_addr, alu_tab[i].exp);
      check($sformatf("alu_zero_%0d", i), {31'b0, zero}, {31'b0, alu_tab[i].exp_zero});
      idle();
    end

    // addi x1,x0,5 at RESET_PC
    idle(); reset = 1'b1; tick(); idle();
    fetch(32'h0050_0093);
    check("addi_pc", pc_out, 32'h104);
    adr_src = 1'b1; alu_src_a = 2'b01; alu_src_b = 2'b11; result_src = 2'b10; #1;
    check("addi_oldpc", mem_addr, 32'h100);
    idle(); alu_src_a = 2'b10; alu_src_b = 2'b01; tick();
    idle(); reg_write = 1'b1; tick(); idle();

    // sw x1,8(x0)
    fetch(32'h0010_2423);
    alu_src_a = 2'b10; alu_src_b = 2'b01; imm_src = 3'b001; tick();
    idle(); adr_src = 1'b1; mem_write = 1'b1; #1;
    check("sw_addr", mem_addr, 32'h8);
    check("sw_wdata", mem_wdata, 32'h5);
    check("sw_we", {31'b0, mem_we}, 32'h1);
    tick(); idle();

    // lw x2,8(x0)
    fetch(32'h0080_2103);
    alu_src_a = 2'b10; alu_src_b = 2'b01; tick();
    idle(); adr_src = 1'b1; mem_rdata = 32'h5; #1;
    check("lw_addr", mem_addr, 32'h8);
    tick();
    idle(); reg_write = 1'b1; result_src = 2'b01; tick(); idle();
    check("lw_pc", pc_out, 32'h10C);

    // beq x1,x2,-8 at 0x10C, taken to 0x104
    fetch(32'hFE20_8CE3);
    alu_src_a = 2'b01; alu_src_b = 2'b01; imm_src = 3'b010; tick();
    idle(); alu_src_a = 2'b10; alu_src_b = 2'b00; alu_control = 3'b001; pc_write = 1'b1; #1;
    check("beq_zero", {31'b0, zero}, 32'h1);
    tick(); idle();
    check("beq_pc", pc_out, 32'h104);
    read_reg(5'd1, rv); check("addi_x1", rv, 32'h5);
    read_reg(5'd2, rv); check("lw_x2", rv, 32'h5);

    // jal x1,+16 at 0x200
    load_pc(32'h200);
    check("jal_setup_pc", pc_out, 32'h200);
    fetch(32'h0100_00EF);
    check("jal_fetch_pc", pc_out, 32'h204);
    alu_src_a = 2'b01; alu_src_b = 2'b01; imm_src = 3'b011; tick();
    idle(); pc_write = 1'b1; tick();
    idle(); alu_src_a = 2'b01; alu_src_b = 2'b10; result_src = 2'b10; reg_write = 1'b1; tick();
    idle();
    check("jal_pc", pc_out, 32'h210);
    read_reg(5'd1, rv); check("jal_link", rv, 32'h204);

    // x0 stays zero
    write_reg(5'd0, 32'hDEAD, 5'd0, 5'd0);
    read_reg(5'd0, rv); check("x0_write", rv, 32'h0);

    // reg_write with ir_write: destination comes from the old IR (x7, not x8)
    idle(); ir_write = 1'b1; mem_rdata = {7'b0, 5'd0, 5'd0, 3'b000, 5'd7, 7'h33}; tick();
    idle(); mem_rdata = 32'h77; tick();
    idle(); ir_write = 1'b1; reg_write = 1'b1; result_src = 2'b01;
    mem_rdata = {7'b0, 5'd0, 5'd0, 3'b000, 5'd8, 7'h33}; tick(); idle();
    read_reg(5'd7, rv); check("dual_write_x7", rv, 32'h77);
    read_reg(5'd8, rv); check("dual_write_x8", rv, 32'h0);

    // PC wrap
    load_pc(32'hFFFF_FFFC);
    fetch(32'h0000_0013);
    check("pc_wrap", pc_out, 32'h0);

    // reset during a writeback cycle
    idle(); ir_write = 1'b1; mem_rdata = {7'b0, 5'd0, 5'd0, 3'b000, 5'd4, 7'h33}; tick();
    idle(); mem_rdata = 32'h55; tick();
    idle(); reg_write = 1'b1; result_src = 2'b01; reset = 1'b1; tick(); idle();
    check("midrst_pc", pc_out, RESET_PC);
    check("midrst_opcode", {25'b0, opcode}, 32'h13);
    read_reg(5'd4, rv); check("midrst_x4", rv, 32'h0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
